// File: rtl/disp_pkg.sv
// Shared types and constants for the calculator display controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Calculator status encodings
    localparam logic [1:0] STAT_ERROR = 2'b00;
    localparam logic [1:0] STAT_BUSY  = 2'b01;
    localparam logic [1:0] STAT_READY = 2'b10;
    localparam logic [1:0] STAT_PRINT = 2'b11;

    // Digit codes: 0-9 are decimal, A/B/C spell the error word, F is blank
    localparam logic [3:0] CODE_0     = 4'h0;
    localparam logic [3:0] CODE_E     = 4'hA;
    localparam logic [3:0] CODE_R     = 4'hB;
    localparam logic [3:0] CODE_O     = 4'hC;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Active-low segment patterns, bit order g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/disp_if.sv
// Calculator-to-display bundle: digit stream in, multiplexed LED drive out.
// Latency: n/a (wires only).
// Backpressure: none; the calculator paces itself via status.
interface disp_if;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_valid;

    modport master (output status, data, pos, input an, seg, dp, frame_valid);
    modport slave  (input status, data, pos, output an, seg, dp, frame_valid);
endinterface

// File: rtl/seg7_dec.sv
// Maps a 4-bit digit code to an active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_dec
    import disp_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Code-to-pattern lookup; unused codes stay dark
    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            CODE_E:  seg_o = SEG_E;
            CODE_R:  seg_o = SEG_R;
            CODE_O:  seg_o = SEG_O;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_ctrl.sv
// Collects calculator digits into a shadow frame, commits it, scans 8 LED digits.
// Latency: committed frame reaches seg one edge after commit; an/seg/dp registered.
// Backpressure: none; busy status simply pauses loading.
module disp_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic   clock,
    input  logic   reset,
    disp_if.slave  bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    state_t           state_q, state_d;
    logic [3:0]       shadow_q [8];
    logic [3:0]       shadow_d [8];
    logic [3:0]       disp_q   [8];
    logic [3:0]       disp_d   [8];
    logic             fv_q, fv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [7:0]       lit;
    logic [3:0]       code_sel;
    logic [2:0]       wr_idx;

    assign wr_idx = 3'(bus.pos - 4'd1);

    // Next state: error status overrides everything, otherwise load/commit flow
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        fv_d     = fv_q;
        if (bus.status == STAT_ERROR) begin
            state_d = ST_ERR;
            fv_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.status == STAT_PRINT) begin
                        state_d = ST_LOAD;
                        for (int i = 0; i < 8; i++) shadow_d[i] = CODE_BLANK;
                    end
                end
                ST_LOAD: begin
                    if (bus.status == STAT_PRINT) begin
                        if (bus.pos >= 4'd1 && bus.pos <= 4'd8)
                            shadow_d[wr_idx] = (bus.data > 4'd9) ? CODE_BLANK : bus.data;
                    end else if (bus.status == STAT_READY) begin
                        disp_d  = shadow_q;
                        fv_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state_d = ST_IDLE;
                    fv_d    = 1'b0;
                    for (int i = 0; i < 8; i++) disp_d[i] = CODE_BLANK;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Refresh divider and digit index advance
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Leading-zero mask: a digit lights if it or any higher digit is non-zero
    always_comb begin : lz_mask
        logic seen;
        seen = 1'b0;
        lit  = '0;
        for (int i = 7; i >= 0; i--) begin
            seen   = seen | (disp_q[i] != CODE_0);
            lit[i] = seen;
        end
        lit[0] = 1'b1;
    end

    // Pick the code for the digit being enabled on the next edge
    always_comb begin
        code_sel = CODE_BLANK;
        if (state_q == ST_ERR) begin
            case (idx_d)
                3'd0:    code_sel = CODE_O;
                3'd1:    code_sel = CODE_R;
                3'd2:    code_sel = CODE_R;
                3'd3:    code_sel = CODE_E;
                default: code_sel = CODE_BLANK;
            endcase
        end else if (fv_q && lit[idx_d]) begin
            code_sel = disp_q[idx_d];
        end
    end

    seg7_dec u_dec (
        .code_i (code_sel),
        .seg_o  (seg_d)
    );

    assign dp_d = !((bus.status == STAT_BUSY) && (idx_d == 3'd0));

    // State, buffers, scan position and registered LED drive
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            fv_q    <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= CODE_BLANK;
                disp_q[i]   <= CODE_BLANK;
            end
        end else begin
            state_q  <= state_d;
            fv_q     <= fv_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= ~(8'd1 << idx_d);
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_disp_ctrl.sv
// Directed bench for disp_ctrl with a fast refresh divider.
// Latency: n/a.
// Backpressure: n/a.
module tb_disp_ctrl;
    import disp_pkg::*;

    logic clock = 1'b0;
    logic reset;
    disp_if ifc ();

    disp_ctrl #(.REFRESH_DIV(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [6:0] cap [8];
    int dp_fe_low, dp_fe_high, dp_other_low;
    logic [7:0] s [40];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Let the inputs settle into seg, then record seg per enabled digit over a full scan
    task automatic capture();
        repeat (2) @(negedge clock);
        for (int j = 0; j < 8; j++) cap[j] = 7'h00;
        dp_fe_low = 0; dp_fe_high = 0; dp_other_low = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clock);
            for (int j = 0; j < 8; j++)
                if (ifc.an === ~(8'd1 << j)) cap[j] = ifc.seg;
            if (ifc.an === 8'hFE) begin
                if (ifc.dp === 1'b0) dp_fe_low++; else dp_fe_high++;
            end else if (ifc.dp !== 1'b1) begin
                dp_other_low++;
            end
        end
    endtask

    task automatic load_frame(input logic [31:0] digits);
        @(negedge clock);
        ifc.status = STAT_PRINT; ifc.pos = 4'd0; ifc.data = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            ifc.pos  = 4'(k);
            ifc.data = digits[4*(k-1) +: 4];
        end
    endtask

    // Ready cycle carries junk pos/data that must not be written
    task automatic commit();
        @(negedge clock);
        ifc.status = STAT_READY; ifc.pos = 4'd1; ifc.data = 4'd9;
        @(negedge clock);
        ifc.pos = 4'd0; ifc.data = 4'd0;
    endtask

    initial begin
        int first;
        logic [7:0] exp_an;
        reset = 1'b0;
        ifc.status = STAT_READY; ifc.data = 4'd0; ifc.pos = 4'd0;

        // Reset state
        @(negedge clock);
        check("rst_an", 32'(ifc.an), 32'hFF);
        check("rst_seg", 32'(ifc.seg), 32'h7F);
        check("rst_dp", 32'(ifc.dp), 32'h1);
        check("rst_fv", 32'(ifc.frame_valid), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("idle_fv", 32'(ifc.frame_valid), 32'h0);

        // Frame 125 plus out-of-range positions that must be ignored
        load_frame(32'h0000_0125);
        @(negedge clock); ifc.pos = 4'd9;  ifc.data = 4'd7;
        @(negedge clock); ifc.pos = 4'd0;  ifc.data = 4'd3;
        @(negedge clock); ifc.pos = 4'd15; ifc.data = 4'd4;
        commit();
        check("f125_fv", 32'(ifc.frame_valid), 32'h1);
        capture();
        check("f125_d0", 32'(cap[0]), 32'h12);
        check("f125_d1", 32'(cap[1]), 32'h24);
        check("f125_d2", 32'(cap[2]), 32'h79);
        for (int j = 3; j < 8; j++) check($sformatf("f125_d%0d", j), 32'(cap[j]), 32'h7F);
        check("f125_dp_fe", 32'(dp_fe_low), 32'd0);
        check("f125_dp_other", 32'(dp_other_low), 32'd0);

        // All-zero frame keeps only digit 0
        load_frame(32'h0000_0000);
        commit();
        capture();
        check("zero_d0", 32'(cap[0]), 32'h40);
        for (int j = 1; j < 8; j++) check($sformatf("zero_d%0d", j), 32'(cap[j]), 32'h7F);

        // Data above 9 stored as blank
        load_frame(32'h0000_00C7);
        commit();
        capture();
        check("big_d0", 32'(cap[0]), 32'h78);
        check("big_d1", 32'(cap[1]), 32'h7F);
        check("big_d2", 32'(cap[2]), 32'h7F);

        // Busy in IDLE: decimal point on digit 0 only, frame untouched
        @(negedge clock); ifc.status = STAT_BUSY;
        capture();
        check("busy_dp_fe_high", 32'(dp_fe_high), 32'd0);
        check("busy_dp_fe_seen", 32'(dp_fe_low != 0), 32'd1);
        check("busy_dp_other", 32'(dp_other_low), 32'd0);
        check("busy_d0", 32'(cap[0]), 32'h78);
        check("busy_fv", 32'(ifc.frame_valid), 32'h1);

        // Error mid-load
        @(negedge clock); ifc.status = STAT_PRINT; ifc.pos = 4'd0;
        @(negedge clock); ifc.pos = 4'd1; ifc.data = 4'd1;
        @(negedge clock); ifc.pos = 4'd2; ifc.data = 4'd2;
        @(negedge clock); ifc.pos = 4'd3; ifc.data = 4'd3;
        @(negedge clock); ifc.status = STAT_ERROR; ifc.pos = 4'd4; ifc.data = 4'd4;
        @(negedge clock);
        check("err_fv", 32'(ifc.frame_valid), 32'h0);
        capture();
        check("err_d0", 32'(cap[0]), 32'h23);
        check("err_d1", 32'(cap[1]), 32'h2F);
        check("err_d2", 32'(cap[2]), 32'h2F);
        check("err_d3", 32'(cap[3]), 32'h06);
        check("err_d4", 32'(cap[4]), 32'h7F);
        check("err_d7", 32'(cap[7]), 32'h7F);
        ifc.status = STAT_READY;
        capture();
        check("post_err_fv", 32'(ifc.frame_valid), 32'h0);
        for (int j = 0; j < 8; j++) check($sformatf("post_err_d%0d", j), 32'(cap[j]), 32'h7F);

        // Scan order and hold time
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            s[c] = ifc.an;
        end
        first = -1;
        for (int c = 20; c >= 1; c--)
            if (s[c] == 8'hFE && s[c-1] != 8'hFE) first = c;
        check("scan_found", 32'(first > 0), 32'd1);
        if (first < 1) first = 1;
        for (int k = 0; k < 9; k++) begin
            exp_an = ~(8'd1 << (k % 8));
            check($sformatf("scan_%0d_a", k), 32'(s[first + 2*k]), 32'(exp_an));
            check($sformatf("scan_%0d_b", k), 32'(s[first + 2*k + 1]), 32'(exp_an));
        end

        // Reset mid-scan during a partial load
        load_frame(32'h0000_0125);
        commit();
        @(negedge clock); ifc.status = STAT_PRINT; ifc.pos = 4'd0;
        @(negedge clock); ifc.pos = 4'd1; ifc.data = 4'd9;
        @(negedge clock); ifc.status = STAT_BUSY;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_an", 32'(ifc.an), 32'hFF);
        check("mid_rst_seg", 32'(ifc.seg), 32'h7F);
        check("mid_rst_dp", 32'(ifc.dp), 32'h1);
        check("mid_rst_fv", 32'(ifc.frame_valid), 32'h0);
        @(negedge clock);
        ifc.status = STAT_READY; ifc.pos = 4'd0; ifc.data = 4'd0;
        reset = 1'b1;
        capture();
        check("rst_discard_fv", 32'(ifc.frame_valid), 32'h0);
        check("rst_discard_d0", 32'(cap[0]), 32'h7F);
        check("rst_discard_d1", 32'(cap[1]), 32'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
